// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the full-parallel FFT datapath: the input packer,
// the butterfly stages and the weight buffer.
//   FFT_NPOINT / FFT_WIDTH : default transform size (log2) and component width
//   LANES / FRAME_W        : lane count and packed-bus width for the defaults
//   complex_sample_t       : one complex sample {re, im}
//   bitrev()               : reverse the low nbits of a value
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_NPOINT = 3;
    localparam int FFT_WIDTH  = 16;
    localparam int LANES      = 2**FFT_NPOINT;
    localparam int FRAME_W    = FFT_WIDTH * LANES;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } complex_sample_t;

    // Shifts bits out of the LSB of value and into the LSB of the result,
    // so after nbits steps the low nbits appear in reversed order.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
        logic [31:0] v;
        logic [31:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r = {r[30:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_packer_if.sv
// ---------------------------------------------------------------------------
// fft_input_packer_if
// Serial sample input and parallel frame output of the FFT input packer.
//   din_valid/din_busy   : serial handshake, transfer when valid & !busy
//   din_sof              : start-of-frame marker qualified by a transfer
//   din_real/din_imag    : serial sample components
//   dout_valid/dout_busy : frame handshake, transfer when valid & !busy
//   dout_real/dout_imag  : packed frame, lane k at [k*WIDTH +: WIDTH]
//   frame_err            : one-cycle pulse when a partial frame is dropped
// Modports: slave = packer side, master = source/sink side.
// ---------------------------------------------------------------------------
interface fft_input_packer_if #(
    parameter int NPOINT = 3,
    parameter int WIDTH  = 16
);
    localparam int BUS_W = WIDTH * (2**NPOINT);

    logic                    din_valid;
    logic                    din_busy;
    logic                    din_sof;
    logic signed [WIDTH-1:0] din_real;
    logic signed [WIDTH-1:0] din_imag;
    logic                    dout_valid;
    logic                    dout_busy;
    logic [BUS_W-1:0]        dout_real;
    logic [BUS_W-1:0]        dout_imag;
    logic                    frame_err;

    modport slave (
        input  din_valid, din_sof, din_real, din_imag, dout_busy,
        output din_busy, dout_valid, dout_real, dout_imag, frame_err
    );

    modport master (
        output din_valid, din_sof, din_real, din_imag, dout_busy,
        input  din_busy, dout_valid, dout_real, dout_imag, frame_err
    );
endinterface

// File: rtl/fft_input_packer.sv
// ---------------------------------------------------------------------------
// fft_input_packer
// Serial-to-parallel front end for the full-parallel FFT. Collects 2**NPOINT
// complex samples into a fill bank in first-butterfly lane order and hands
// the finished frame to a double-buffered output register.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active low
//   bus   : fft_input_packer_if.slave (serial in, parallel out, frame_err)
//
// Build option:
//   FFT_INPUT_BITREV_EN defined   -> sample c lands in lane bitrev(c)
//                                    (decimation-in-time input order)
//   FFT_INPUT_BITREV_EN undefined -> sample c lands in lane c
// ---------------------------------------------------------------------------
module fft_input_packer
    import fft_pkg::*;
#(
    parameter int NPOINT = FFT_NPOINT,
    parameter int WIDTH  = FFT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_input_packer_if.slave bus
);

    localparam int                NLANES   = 2**NPOINT;
    localparam int                BUS_W    = WIDTH * NLANES;
    localparam logic [NPOINT-1:0] LAST_IDX = NPOINT'(NLANES - 1);

    function automatic logic [NPOINT-1:0] lane_idx(input logic [NPOINT-1:0] c);
`ifdef FFT_INPUT_BITREV_EN
        logic [31:0] r;
        r = bitrev({{(32-NPOINT){1'b0}}, c}, NPOINT);
        return r[NPOINT-1:0];
`else
        return c;
`endif
    endfunction

    logic [NPOINT-1:0] cnt_p0;
    logic              bank_full_p0;
    logic [WIDTH-1:0]  fill_re_p0 [NLANES];
    logic [WIDTH-1:0]  fill_im_p0 [NLANES];

    logic              vld_p1;
    logic              frame_err_p1;
    logic [BUS_W-1:0]  out_re_p1;
    logic [BUS_W-1:0]  out_im_p1;

    logic              xfer_in;
    logic              out_free;
    logic              last_in;
    logic              load_out;
    logic [NPOINT-1:0] wr_cnt;
    logic [NPOINT-1:0] wr_lane;
    logic [BUS_W-1:0]  frame_re;
    logic [BUS_W-1:0]  frame_im;

    // A new frame forces the write position back to 0 regardless of cnt.
    assign xfer_in  = bus.din_valid & ~bank_full_p0;
    assign out_free = ~vld_p1 | ~bus.dout_busy;
    assign wr_cnt   = bus.din_sof ? '0 : cnt_p0;
    assign wr_lane  = lane_idx(wr_cnt);
    assign last_in  = xfer_in & (wr_cnt == LAST_IDX);
    // bank_full and last_in are exclusive because a full bank blocks input.
    assign load_out = out_free & (last_in | bank_full_p0);

    // Frame as it would look after this edge: the bank with the incoming
    // sample merged into its lane. With a full bank no sample is accepted,
    // so this is simply the held bank.
    always_comb begin
        frame_re = '0;
        frame_im = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (xfer_in && (wr_lane == NPOINT'(k))) begin
                frame_re[k*WIDTH +: WIDTH] = bus.din_real;
                frame_im[k*WIDTH +: WIDTH] = bus.din_imag;
            end else begin
                frame_re[k*WIDTH +: WIDTH] = fill_re_p0[k];
                frame_im[k*WIDTH +: WIDTH] = fill_im_p0[k];
            end
        end
    end

    // ---- stage p0: serial fill bank ----
    always_ff @(posedge clk) begin
        if (xfer_in) begin
            fill_re_p0[wr_lane] <= bus.din_real;
            fill_im_p0[wr_lane] <= bus.din_imag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0       <= '0;
            bank_full_p0 <= 1'b0;
            frame_err_p1 <= 1'b0;
        end else begin
            frame_err_p1 <= xfer_in & bus.din_sof & (cnt_p0 != '0);
            if (xfer_in) begin
                cnt_p0 <= wr_cnt + NPOINT'(1);
            end
            if (last_in && !out_free) begin
                bank_full_p0 <= 1'b1;
            end else if (bank_full_p0 && out_free) begin
                bank_full_p0 <= 1'b0;
            end
        end
    end

    // ---- stage p1: parallel output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            out_re_p1 <= '0;
            out_im_p1 <= '0;
        end else begin
            if (load_out) begin
                vld_p1    <= 1'b1;
                out_re_p1 <= frame_re;
                out_im_p1 <= frame_im;
            end else if (!bus.dout_busy) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.din_busy   = bank_full_p0;
    assign bus.dout_valid = vld_p1;
    assign bus.dout_real  = out_re_p1;
    assign bus.dout_imag  = out_im_p1;
    assign bus.frame_err  = frame_err_p1;

endmodule

// File: tb/tb_fft_input_packer.sv
// ---------------------------------------------------------------------------
// tb_fft_input_packer
// Directed bench for fft_input_packer at NPOINT=3, WIDTH=16. Expected lane
// order follows FFT_INPUT_BITREV_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_fft_input_packer;
    import fft_pkg::*;

    localparam int NP = FFT_NPOINT;
    localparam int W  = FFT_WIDTH;
    localparam int FW = FRAME_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_input_packer_if #(.NPOINT(NP), .WIDTH(W)) bus ();

    fft_input_packer #(.NPOINT(NP), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic int lane_of(int c);
`ifdef FFT_INPUT_BITREV_EN
        return ((c & 1) << 2) | (c & 2) | ((c >> 2) & 1);
`else
        return c;
`endif
    endfunction

    // Frame whose serial sample i carries value base+i.
    function automatic logic [FW-1:0] frame(int base);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < LANES; i++) begin
            f[lane_of(i)*W +: W] = W'(base + i);
        end
        return f;
    endfunction

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkf(string tag, logic [FW-1:0] obs, logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_sample(logic sof, int re, int im);
        bus.din_valid = 1'b1;
        bus.din_sof   = sof;
        bus.din_real  = W'(re);
        bus.din_imag  = W'(im);
    endtask

    // Invalid cycle carrying junk data and a stray sof that must be ignored.
    task automatic idle();
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b1;
        bus.din_real  = W'(999);
        bus.din_imag  = W'(999);
    endtask

    initial begin
        int sent;
        int cyc;
        logic v;

        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
        bus.din_real  = '0;
        bus.din_imag  = '0;
        bus.dout_busy = 1'b0;

        // Reset state
        #12;
        chk1("rst_dout_valid", bus.dout_valid, 1'b0);
        chk1("rst_din_busy", bus.din_busy, 1'b0);
        chk1("rst_frame_err", bus.frame_err, 1'b0);
        chkf("rst_dout_real", bus.dout_real, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single frame, latency 1 cycle after the 8th transfer
        for (int i = 0; i < 8; i++) begin
            put_sample(i == 0, i, 100 + i);
            tick();
            if (i == 6) chk1("s1_not_yet", bus.dout_valid, 1'b0);
        end
        chk1("s1_valid", bus.dout_valid, 1'b1);
        chkf("s1_real", bus.dout_real, frame(0));
        chkf("s1_imag", bus.dout_imag, frame(100));
        chk1("s1_no_err", bus.frame_err, 1'b0);
        idle();
        tick();
        chk1("s1_drained", bus.dout_valid, 1'b0);

        // Back-pressure: frame 1 held, frame 2 parks in the bank
        bus.dout_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put_sample(i == 0, 10 + i, 200 + i);
            tick();
            if (i == 11) chkf("s2_hold_mid", bus.dout_real, frame(10));
        end
        chk1("s2_valid", bus.dout_valid, 1'b1);
        chkf("s2_f1_real", bus.dout_real, frame(10));
        chkf("s2_f1_imag", bus.dout_imag, frame(200));
        chk1("s2_din_busy", bus.din_busy, 1'b1);
        put_sample(1'b0, 99, 99);
        tick();
        chk1("s2_still_busy", bus.din_busy, 1'b1);
        chkf("s2_f1_stable", bus.dout_real, frame(10));
        idle();
        bus.dout_busy = 1'b0;
        tick();
        bus.dout_busy = 1'b1;
        chk1("s2_f2_valid", bus.dout_valid, 1'b1);
        chkf("s2_f2_real", bus.dout_real, frame(18));
        chkf("s2_f2_imag", bus.dout_imag, frame(208));
        chk1("s2_busy_clear", bus.din_busy, 1'b0);
        tick();
        chk1("s2_f2_held", bus.dout_valid, 1'b1);
        bus.dout_busy = 1'b0;
        tick();
        chk1("s2_drained", bus.dout_valid, 1'b0);

        // Continuous stream, no sof: the refused sample must not have moved cnt
        for (int i = 0; i < 24; i++) begin
            put_sample(1'b0, 30 + i, 130 + i);
            tick();
            chk1("s3_din_busy", bus.din_busy, 1'b0);
            if ((i % 8) == 7) begin
                chk1("s3_valid", bus.dout_valid, 1'b1);
                chkf("s3_real", bus.dout_real, frame(30 + i - 7));
                chkf("s3_imag", bus.dout_imag, frame(130 + i - 7));
            end else begin
                chk1("s3_gap", bus.dout_valid, 1'b0);
            end
        end
        idle();
        tick();

        // Partial frame discarded by sof
        for (int i = 0; i < 5; i++) begin
            put_sample(i == 0, 60 + i, 160 + i);
            tick();
            chk1("s4_err_quiet", bus.frame_err, 1'b0);
        end
        put_sample(1'b1, 50, 150);
        tick();
        chk1("s4_err_pulse", bus.frame_err, 1'b1);
        for (int i = 1; i < 8; i++) begin
            put_sample(1'b0, 50 + i, 150 + i);
            tick();
            if (i == 1) chk1("s4_err_one_cycle", bus.frame_err, 1'b0);
        end
        chk1("s4_valid", bus.dout_valid, 1'b1);
        chkf("s4_real", bus.dout_real, frame(50));
        chkf("s4_imag", bus.dout_imag, frame(150));
        idle();
        tick();

        // Gapped input
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 200) begin
            v = 1'($urandom_range(0, 1));
            if (v) put_sample(sent == 0, sent, 100 + sent);
            else   idle();
            tick();
            cyc++;
            if (v) sent++;
            if (sent < 8) chk1("s5_no_early_valid", bus.dout_valid, 1'b0);
        end
        chk1("s5_all_sent", sent == 8, 1'b1);
        chk1("s5_valid", bus.dout_valid, 1'b1);
        chkf("s5_real", bus.dout_real, frame(0));
        chkf("s5_imag", bus.dout_imag, frame(100));
        idle();
        tick();

        // Asynchronous reset with a held frame and a partial fill
        bus.dout_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put_sample(i == 0, 70 + i, 170 + i);
            tick();
        end
        chk1("s6_held_valid", bus.dout_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            put_sample(i == 0, 80 + i, 180 + i);
            tick();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk1("s6_rst_valid", bus.dout_valid, 1'b0);
        chk1("s6_rst_busy", bus.din_busy, 1'b0);
        chk1("s6_rst_err", bus.frame_err, 1'b0);
        chkf("s6_rst_real", bus.dout_real, '0);
        chkf("s6_rst_imag", bus.dout_imag, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dout_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put_sample(i == 0, 90 + i, 190 + i);
            tick();
            chk1("s6_no_err", bus.frame_err, 1'b0);
        end
        chk1("s6_valid", bus.dout_valid, 1'b1);
        chkf("s6_real", bus.dout_real, frame(90));
        chkf("s6_imag", bus.dout_imag, frame(190));
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
